iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// iter_alu: request/response ALU. Single-cycle ops complete in one cycle;
// MUL (shift-add) and DIVU/REMU (restoring division) iterate one bit per
// cycle for WIDTH cycles before presenting the result.
//
// state  | meaning
// IDLE   | ready for a request
// MUL    | shift-add multiply in progress
// DIV    | restoring divide in progress
// DONE   | result valid, waiting for out_ready
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_c,
  output logic             f,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_BLT  = 4'd10;
  localparam logic [3:0] OP_BGE  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;      // multiplicand (MUL) / dividend-then-quotient (DIV)
  logic [WIDTH-1:0] b_q;      // multiplier (MUL) / divisor (DIV)
  logic [WIDTH-1:0] acc_q;    // partial product (MUL) / partial remainder (DIV)
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_c;
  logic             res_f;

  logic             accept;
  logic             last_step;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_c;
  logic             fast_f;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign accept    = in_valid && (state == S_IDLE);
  assign last_step = (cnt_q == '0);
  assign shamt     = op_b[SHW-1:0];

  // Iteration step values; the remainder needs one extra bit because the
  // shifted partial remainder can exceed WIDTH bits before the subtract.
  assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = ~div_diff[WIDTH];
  assign rem_nxt  = q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt  = {a_q[WIDTH-2:0], q_bit};

  // Single-cycle result, computed straight from the request operands.
  always_comb begin
    fast_c = '0;
    fast_f = 1'b0;
    case (alu_op)
      OP_ADD: fast_c = op_a + op_b;
      OP_SUB: fast_c = op_a - op_b;
      OP_SLL: fast_c = op_a << shamt;
      OP_SRL: fast_c = op_a >> shamt;
      OP_SRA: fast_c = $signed(op_a) >>> shamt;
      OP_OR:  fast_c = op_a | op_b;
      OP_XOR: fast_c = op_a ^ op_b;
      OP_AND: fast_c = op_a & op_b;
      OP_BEQ: fast_f = (op_a == op_b);
      OP_BNE: fast_f = (op_a != op_b);
      OP_BLT: fast_f = ($signed(op_a) < $signed(op_b));
      OP_BGE: fast_f = ($signed(op_a) >= $signed(op_b));
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_op == OP_MUL)                            state_nxt = S_MUL;
          else if (alu_op == OP_DIVU || alu_op == OP_REMU) state_nxt = S_DIV;
          else                                             state_nxt = S_DONE;
        end
      end
      S_MUL:  if (last_step) state_nxt = S_DONE;
      S_DIV:  if (last_step) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_MUL) || (state == S_DIV);
  end

  // Datapath: capture on accept, iterate in MUL/DIV, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_c <= '0;
      res_f <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= alu_op;
            a_q   <= op_a;
            b_q   <= op_b;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            if (alu_op != OP_MUL && alu_op != OP_DIVU && alu_op != OP_REMU) begin
              res_c <= fast_c;
              res_f <= fast_f;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_sum;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - 1'b1;
          if (last_step) begin
            res_c <= mul_sum;
            res_f <= 1'b0;
          end
        end
        S_DIV: begin
          acc_q <= rem_nxt;
          a_q   <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (last_step) begin
            res_c <= (op_q == OP_DIVU) ? quo_nxt : rem_nxt;
            res_f <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_c = res_c;
  assign f     = res_f;

endmodule
